iir_cascade_sched: RTL and testbench

- Time-multiplexed scheduler for the biquad IIR cascade. It runs each input sample through 1–3 second-order sections on one shared multiply-accumulate datapath.
- Owns the coefficient register file, the per-section delay-line state and the section/tap sequencing FSM.
- Sits between the sample source and sink. It replaces three instantiated section filters with one MAC.

---
 rtl/iir_cascade_sched.sv | 186 ++++++++++++++++++
 tb/tb_iir_cascade_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/iir_cascade_sched.sv
// Biquad IIR cascade scheduler: runs up to NSEC direct-form-I sections per
// sample on one shared MAC, with its own coefficient file and delay lines.
module iir_cascade_sched #(
  parameter int W    = 16,
  parameter int FRAC = 14,
  parameter int NSEC = 3,
  parameter int ACCW = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   order,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         clr_state,
  output logic         busy
);

  localparam int NCOEF = NSEC * 5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [ACCW:0] RND     = (ACCW+1)'(2**(FRAC-1));
  localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'(2**(W-1)-1);
  localparam logic signed [ACCW:0] SAT_MIN = (ACCW+1)'(-(2**(W-1)));

  logic [1:0]             state_q, state_d;
  logic [1:0]             sec_q, sec_d;
  logic [2:0]             tap_q, tap_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [W-1:0]    xin_q, xin_d;
  logic [3:0]             ord_q, ord_d;
  logic [W-1:0]           out_q, out_d;
  logic                   rdy_q, rdy_d;

  logic signed [W-1:0] coef_q [NCOEF];
  logic signed [W-1:0] coef_d [NCOEF];
  logic signed [W-1:0] x1_q [NSEC];
  logic signed [W-1:0] x1_d [NSEC];
  logic signed [W-1:0] x2_q [NSEC];
  logic signed [W-1:0] x2_d [NSEC];
  logic signed [W-1:0] y1_q [NSEC];
  logic signed [W-1:0] y1_d [NSEC];
  logic signed [W-1:0] y2_q [NSEC];
  logic signed [W-1:0] y2_d [NSEC];

  logic [3:0]             cidx;
  logic signed [W-1:0]    coef, opnd;
  logic signed [2*W-1:0]  ca, oa, prod;
  logic signed [ACCW-1:0] pext;
  logic signed [ACCW:0]   rsum, rsh;
  logic signed [W-1:0]    r_sat;

  // Shared MAC datapath: operand selected by tap, product sign-extended to ACCW.
  always_comb begin
    cidx = {2'b00, sec_q} * 4'd5 + {1'b0, tap_q};
    coef = coef_q[cidx];
    case (tap_q)
      3'd0:    opnd = xin_q;
      3'd1:    opnd = x1_q[sec_q];
      3'd2:    opnd = x2_q[sec_q];
      3'd3:    opnd = y1_q[sec_q];
      default: opnd = y2_q[sec_q];
    endcase
    ca   = {{W{coef[W-1]}}, coef};
    oa   = {{W{opnd[W-1]}}, opnd};
    prod = ca * oa;
    pext = {{(ACCW-2*W){prod[2*W-1]}}, prod};
    rsum = {acc_q[ACCW-1], acc_q} + RND;
    rsh  = rsum >>> FRAC;
    if (rsh > SAT_MAX)      r_sat = SAT_MAX[W-1:0];
    else if (rsh < SAT_MIN) r_sat = SAT_MIN[W-1:0];
    else                    r_sat = rsh[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    xin_d   = xin_q;
    ord_d   = ord_q;
    out_d   = out_q;
    coef_d  = coef_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_we && int'(cfg_addr) < NCOEF) coef_d[cfg_addr] = cfg_data;
        if (clr_state) begin
          x1_d = '{default: '0};
          x2_d = '{default: '0};
          y1_d = '{default: '0};
          y2_d = '{default: '0};
        end
        if (in_valid && rdy_q) begin
          xin_d = in_data;
          ord_d = order;
          if (order == 4'd0 || int'(order) > NSEC) begin
            out_d   = '0;
            state_d = S_OUT;
          end else begin
            sec_d   = '0;
            tap_d   = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        // Feedback taps (a1, a2) are subtracted.
        acc_d = (tap_q >= 3'd3) ? acc_q - pext : acc_q + pext;
        if (tap_q == 3'd4) state_d = S_WB;
        else               tap_d   = tap_q + 3'd1;
      end
      S_WB: begin
        x2_d[sec_q] = x1_q[sec_q];
        x1_d[sec_q] = xin_q;
        y2_d[sec_q] = y1_q[sec_q];
        y1_d[sec_q] = r_sat;
        xin_d       = r_sat;
        if ({2'b00, sec_q} < ord_q - 4'd1) begin
          sec_d   = sec_q + 2'd1;
          tap_d   = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end else begin
          out_d   = r_sat;
          state_d = S_OUT;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sec_q   <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      xin_q   <= '0;
      ord_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
      coef_q  <= '{default: '0};
      x1_q    <= '{default: '0};
      x2_q    <= '{default: '0};
      y1_q    <= '{default: '0};
      y2_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      xin_q   <= xin_d;
      ord_q   <= ord_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      coef_q  <= coef_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = out_q;
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_iir_cascade_sched.sv
// Bench for iir_cascade_sched: table of config/sample steps with expected
// outputs and latencies, plus hand sequences for backpressure, reset and clear.
module tb_iir_cascade_sched;

  localparam int K_CFG = 0;
  localparam int K_CLR = 1;
  localparam int K_SMP = 2;

  typedef struct {
    int kind;
    int a;    // cfg address or order
    int d;    // cfg data or input sample
    int exp;
    int lat;
  } vec_t;

  typedef struct {
    int data;
    int lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  order = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        clr_state = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  exp_t sb[$];

  iir_cascade_sched #(.W(16), .FRAC(14), .NSEC(3), .ACCW(36)) dut (
    .clk(clk), .reset(reset), .order(order), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .clr_state(clr_state),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_cfg(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 16'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_clr();
    clr_state = 1'b1;
    @(negedge clk);
    clr_state = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", int'(in_ready), 1);
  endtask

  task automatic do_sample(input int ord, input int x, input int exp, input int lat, input bit clr);
    int n;
    exp_t e;
    wait_ready();
    sb.push_back('{data: exp, lat: lat});
    order = 4'(ord); in_data = 16'(x); in_valid = 1'b1; clr_state = clr;
    @(negedge clk);
    in_valid = 1'b0; clr_state = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("out_valid_seen", int'(out_valid), 1);
    e = sb.pop_front();
    chk($sformatf("out_data ord=%0d x=%0d", ord, x), int'($signed(out_data)), e.data);
    chk($sformatf("latency ord=%0d", ord), n, e.lat);
    @(negedge clk);
    chk("out_taken", int'(out_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t e;
    logic [15:0] held;

    // bypass
    tbl.push_back(vec_t'{K_CFG, 0, 16'h4000, 0, 0});
    tbl.push_back(vec_t'{K_SMP, 1, 1000, 1000, 6});
    // single pole a1 = -0.5
    tbl.push_back(vec_t'{K_CFG, 3, 16'hE000, 0, 0});
    tbl.push_back(vec_t'{K_CLR, 0, 0, 0, 0});
    tbl.push_back(vec_t'{K_SMP, 1, 1000, 1000, 6});
    tbl.push_back(vec_t'{K_SMP, 1, 0, 500, 6});
    tbl.push_back(vec_t'{K_SMP, 1, 0, 250, 6});
    tbl.push_back(vec_t'{K_SMP, 1, 0, 125, 6});
    tbl.push_back(vec_t'{K_SMP, 1, 0, 63, 6});
    // saturation
    tbl.push_back(vec_t'{K_CFG, 3, 0, 0, 0});
    tbl.push_back(vec_t'{K_CFG, 0, 16'h7FFF, 0, 0});
    tbl.push_back(vec_t'{K_CLR, 0, 0, 0, 0});
    tbl.push_back(vec_t'{K_SMP, 1, 30000, 32767, 6});
    tbl.push_back(vec_t'{K_SMP, 1, -30000, -32768, 6});
    // three-section cascade
    tbl.push_back(vec_t'{K_CFG, 0, 16'h4000, 0, 0});
    tbl.push_back(vec_t'{K_CFG, 5, 16'h4000, 0, 0});
    tbl.push_back(vec_t'{K_CFG, 10, 16'h4000, 0, 0});
    tbl.push_back(vec_t'{K_CLR, 0, 0, 0, 0});
    tbl.push_back(vec_t'{K_SMP, 3, -1234, -1234, 18});
    // order 2 leaves sec2 untouched: sec2 then outputs b1*x1 = 0
    tbl.push_back(vec_t'{K_CLR, 0, 0, 0, 0});
    tbl.push_back(vec_t'{K_SMP, 2, 500, 500, 12});
    tbl.push_back(vec_t'{K_CFG, 10, 0, 0, 0});
    tbl.push_back(vec_t'{K_CFG, 11, 16'h4000, 0, 0});
    tbl.push_back(vec_t'{K_SMP, 3, 0, 0, 18});
    tbl.push_back(vec_t'{K_CFG, 11, 0, 0, 0});
    tbl.push_back(vec_t'{K_CFG, 10, 16'h4000, 0, 0});
    // order 0 and out of range
    tbl.push_back(vec_t'{K_SMP, 0, 777, 0, 0});
    tbl.push_back(vec_t'{K_SMP, 5, 777, 0, 0});

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", int'(in_ready), 1);

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_CFG:   do_cfg(tbl[i].a, tbl[i].d);
        K_CLR:   do_clr();
        default: do_sample(tbl[i].a, tbl[i].d, tbl[i].exp, tbl[i].lat, 1'b0);
      endcase
    end

    // backpressure with a locked-out coefficient write
    do_clr();
    out_ready = 1'b0;
    wait_ready();
    sb.push_back('{data: 321, lat: 6});
    order = 4'd1; in_data = 16'd321; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    e = sb.pop_front();
    chk("bp_latency", n, e.lat);
    held = out_data;
    chk("bp_out_data", int'($signed(held)), e.data);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'h2000; end
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_stable", int'(out_data), int'(held));
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
      cfg_we = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", int'(out_valid), 0);
    do_sample(1, 1000, 1000, 6, 1'b0);

    // reset in the middle of MAC
    wait_ready();
    order = 4'd1; in_data = 16'd1000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_sample(1, 1000, 0, 6, 1'b0);
    do_cfg(0, 16'h4000);
    do_cfg(3, 16'hE000);
    do_clr();
    do_sample(1, 1000, 1000, 6, 1'b0);
    do_sample(1, 0, 500, 6, 1'b0);

    // clear removes the pole tail, alone and together with an accept
    do_clr();
    do_sample(1, 0, 0, 6, 1'b0);
    do_sample(1, 1000, 1000, 6, 1'b0);
    do_sample(1, 0, 0, 6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
